// File: rtl/ms_wb_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : ms_wb_byte_master
//  Description : Byte-stream controlled Wishbone classic initiator. Command
//                packets arriving on the RX byte port become single Wishbone
//                read/write cycles; status and read data are returned as
//                response bytes on the TX byte port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_wb_byte_master #(
    parameter int BUS_TIMEOUT    = 255,
    parameter int RX_GAP_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o
);

    localparam int GAP_W = $clog2(RX_GAP_TIMEOUT + 1);
    localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_TIMEOUT - 1);
    localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_TMO   = 8'h54;
    localparam logic [7:0] RSP_BADOP = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [39:0]        resp_q, resp_d;     // response bytes, next byte in [39:32]
    logic [2:0]         rlen_q, rlen_d;     // response bytes still to send
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [BUS_W-1:0]   bto_q, bto_d;

    logic               rx_fire;
    logic               tx_fire;
    logic               in_bus;

    assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rx_fire    = rx_valid_i & rx_ready_o;
    assign tx_valid_o = (state_q == S_RESP);
    assign tx_fire    = tx_valid_o & tx_ready_i;
    assign tx_data_o  = tx_valid_o ? resp_q[39:32] : 8'h00;
    assign in_bus     = (state_q == S_BUS);
    assign wbm_cyc_o  = in_bus;
    assign wbm_stb_o  = in_bus;
    assign wbm_we_o   = in_bus & we_q;
    assign wbm_sel_o  = in_bus ? 4'hF : 4'h0;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign busy_o     = (state_q != S_IDLE);

    // Next-state, packet assembly, bus timeout and response sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        resp_d  = resp_q;
        rlen_d  = rlen_q;
        gap_d   = gap_q;
        bto_d   = bto_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                        we_d    = (rx_data_i == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = {RSP_BADOP, 32'h0};
                        rlen_d  = 3'd1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR, S_WDATA: begin
                if (rx_fire) begin
                    gap_d = '0;
                    if (state_q == S_ADDR) adr_d = {adr_q[23:0], rx_data_i};
                    else                   dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_ADDR && we_q) state_d = S_WDATA;
                        else                           state_d = S_BUS;
                    end
                end else if (gap_q == GAP_LAST) begin
                    // Stalled partial packet is dropped without a response.
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_BUS: begin
                // Ack takes priority over a timeout on the same edge.
                if (wbm_ack_i) begin
                    resp_d  = {RSP_OK, (we_q ? 32'h0 : wbm_dat_i)};
                    rlen_d  = we_q ? 3'd1 : 3'd5;
                    state_d = S_RESP;
                end else if (bto_q == BUS_LAST) begin
                    resp_d  = {RSP_TMO, 32'h0};
                    rlen_d  = 3'd1;
                    state_d = S_RESP;
                end else begin
                    bto_d = bto_q + 1'b1;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (rlen_q == 3'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        resp_d = {resp_q[31:0], 8'h00};
                        rlen_d = rlen_q - 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte, gap and bus counters restart on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
            gap_d = '0;
            bto_d = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            resp_q  <= '0;
            rlen_q  <= '0;
            gap_q   <= '0;
            bto_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            resp_q  <= resp_d;
            rlen_q  <= rlen_d;
            gap_q   <= gap_d;
            bto_q   <= bto_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ms_wb_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ms_wb_byte_master
//  Description : Self-checking bench for ms_wb_byte_master with a Wishbone
//                slave model and a TX response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ms_wb_byte_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'hA5A5A5A5;
    logic        wbm_ack_i = 1'b0;
    logic        busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // slave model controls and records
    int          ack_wait   = 0;       // ack in BUS cycle index ack_wait (0-based); <0 never
    logic [31:0] rd_data    = 32'h0;
    int          bus_cycles = 0;
    int          cur_len    = 0;
    int          last_len   = 0;
    int          unstable   = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    bit          rand_mode  = 1'b0;
    logic [7:0]  exp_q[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    ms_wb_byte_master #(.BUS_TIMEOUT(8), .RX_GAP_TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // TX sink readiness, changed well away from both clock edges.
    always @(posedge clk_i) begin
        #2;
        tx_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Wishbone slave model: records each cycle and acks after ack_wait cycles.
    always @(negedge clk_i) begin
        if (wbm_cyc_o) begin
            if (cur_len == 0) begin
                bus_cycles++;
                cap_adr = wbm_adr_o;
                cap_dat = wbm_dat_o;
                cap_we  = wbm_we_o;
                cap_sel = wbm_sel_o;
            end else if (wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat || wbm_we_o !== cap_we) begin
                unstable++;
            end
            if (wbm_stb_o !== 1'b1 || wbm_sel_o !== 4'hF) unstable++;
            wbm_ack_i = (ack_wait >= 0) && (cur_len == ack_wait);
            wbm_dat_i = wbm_ack_i ? rd_data : 32'hA5A5A5A5;
            cur_len++;
            last_len = cur_len;
        end else begin
            if (wbm_stb_o !== 1'b0 || wbm_sel_o !== 4'h0 || wbm_we_o !== 1'b0) unstable++;
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'hA5A5A5A5;
            cur_len   = 0;
        end
    end

    // TX scoreboard: pop and compare on every transfer, check stall stability.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (prev_stall) begin
                tests_run++;
                if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data) begin
                    tests_failed++;
                    $display("FAIL tx_stall_hold: valid=%b data=%h required valid=1 data=%h", tx_valid_o, tx_data_o, prev_data);
                end
            end
            if (tx_valid_o) begin
                tests_run++;
                if (rx_ready_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rx_ready_in_resp: got %b required 0", rx_ready_o);
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL tx_unexpected: got %h required no byte", tx_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        tests_failed++;
                        $display("FAIL tx_byte: got %h required %h", tx_data_o, e);
                    end
                end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present one byte at a negedge and hold it until accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (rx_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        tests_run++;
        if (n >= 200) begin
            tests_failed++;
            $display("FAIL rx_accept_timeout: byte %h never accepted, required acceptance", b);
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    // Wait until the block is idle and all expected response bytes are seen.
    task automatic wait_done(input string name);
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        tests_run++;
        if (n >= 500) begin
            tests_failed++;
            $display("FAIL %s_done: busy=%b pending=%0d required busy=0 pending=0", name, busy_o, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (rx_ready_o !== 1'b1 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || wbm_cyc_o !== 1'b0 ||
            wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 ||
            wbm_dat_o !== 32'h0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b txv=%b txd=%h cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h busy=%b required rdy=1 all else 0",
                     rx_ready_o, tx_valid_o, tx_data_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_write();
        int bc = bus_cycles;
        ack_wait = 2;
        exp_q.push_back(8'h4B);
        foreach (wr_pkt[i]) send_byte(wr_pkt[i]);
        wait_done("write");
        tests_run++;
        if (bus_cycles != bc + 1 || cap_adr !== 32'h30000004 || cap_dat !== 32'hDEADBEEF ||
            cap_we !== 1'b1 || cap_sel !== 4'hF || last_len != 3) begin
            tests_failed++;
            $display("FAIL write_cycle: n=%0d adr=%h dat=%h we=%b sel=%h len=%0d required n=1 adr=30000004 dat=deadbeef we=1 sel=f len=3",
                     bus_cycles - bc, cap_adr, cap_dat, cap_we, cap_sel, last_len);
        end
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_busy_after: got %b required 0", busy_o);
        end
    endtask

    task automatic test_read_zero_wait();
        ack_wait = 0;
        rd_data  = 32'h12345678;
        exp_q.push_back(8'h4B); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        wait_done("read0");
        tests_run++;
        if (cap_adr !== 32'h30020008 || cap_we !== 1'b0 || last_len != 1) begin
            tests_failed++;
            $display("FAIL read0_cycle: adr=%h we=%b len=%0d required adr=30020008 we=0 len=1", cap_adr, cap_we, last_len);
        end
        tests_run++;
        if (wbm_dat_o !== 32'hDEADBEEF || wbm_adr_o !== 32'h30020008) begin
            tests_failed++;
            $display("FAIL read0_hold: adr=%h dat=%h required adr=30020008 dat=deadbeef", wbm_adr_o, wbm_dat_o);
        end
    endtask

    task automatic test_bad_opcode();
        int bc = bus_cycles;
        exp_q.push_back(8'hEE);
        send_byte(8'h41);
        wait_done("badop");
        tests_run++;
        if (bus_cycles != bc) begin
            tests_failed++;
            $display("FAIL badop_no_bus: got %0d cycles required 0", bus_cycles - bc);
        end
        ack_wait = 1;
        rd_data  = 32'h89ABCDEF;
        exp_q.push_back(8'h4B); exp_q.push_back(8'h89); exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hEF);
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        wait_done("badop_read");
        tests_run++;
        if (bus_cycles != bc + 1 || last_len != 2) begin
            tests_failed++;
            $display("FAIL badop_followup: n=%0d len=%0d required n=1 len=2", bus_cycles - bc, last_len);
        end
    endtask

    task automatic test_timeout();
        ack_wait = -1;
        exp_q.push_back(8'h54);
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        wait_done("timeout");
        tests_run++;
        if (last_len != 8) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d required 8", last_len);
        end
        ack_wait = 7;
        rd_data  = 32'h0BADF00D;
        exp_q.push_back(8'h4B); exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        wait_done("ack_last");
        tests_run++;
        if (last_len != 8) begin
            tests_failed++;
            $display("FAIL ack_last_len: got %0d required 8", last_len);
        end
    endtask

    task automatic test_tx_backpressure();
        ack_wait = 1;
        rd_data  = 32'hCAFEF00D;
        exp_q.push_back(8'h4B); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
        rand_mode = 1'b1;
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        wait_done("backpressure");
        rand_mode = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || rx_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_end: pending=%0d rdy=%b required pending=0 rdy=1", exp_q.size(), rx_ready_o);
        end
    endtask

    task automatic test_gap_timeout();
        int bc = bus_cycles;
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h00);
        repeat (12) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_early_drop: busy=%b required 1", busy_o);
        end
        repeat (6) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b0 || rx_ready_o !== 1'b1 || bus_cycles != bc) begin
            tests_failed++;
            $display("FAIL gap_drop: busy=%b rdy=%b cycles=%0d required busy=0 rdy=1 cycles=0", busy_o, rx_ready_o, bus_cycles - bc);
        end
    endtask

    task automatic test_reset_mid_bus();
        ack_wait = -1;
        foreach (rd_pkt[i]) send_byte(rd_pkt[i]);
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (wbm_cyc_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_bus_active: cyc=%b required 1", wbm_cyc_o);
        end
        #1 rst_n_i = 1'b0;
        #1;
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async_drop: cyc=%b stb=%b busy=%b txv=%b required all 0", wbm_cyc_o, wbm_stb_o, busy_o, tx_valid_o);
        end
        @(negedge clk_i);
        rst_n_i  = 1'b1;
        @(negedge clk_i);
        ack_wait = 0;
        exp_q.push_back(8'h4B);
        foreach (wr_pkt2[i]) send_byte(wr_pkt2[i]);
        wait_done("after_reset");
        tests_run++;
        if (cap_adr !== 32'h30010000 || cap_dat !== 32'h00000055 || cap_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_reset_write: adr=%h dat=%h we=%b required adr=30010000 dat=00000055 we=1", cap_adr, cap_dat, cap_we);
        end
    endtask

    logic [7:0] wr_pkt[9]  = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] rd_pkt[5]  = '{8'h52, 8'h30, 8'h02, 8'h00, 8'h08};
    logic [7:0] wr_pkt2[9] = '{8'h57, 8'h30, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};

    initial begin
        test_reset();
        test_write();
        test_read_zero_wait();
        test_bad_opcode();
        test_timeout();
        test_tx_backpressure();
        test_gap_timeout();
        test_reset_mid_bus();
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL bus_signal_stability: got %0d violations required 0", unstable);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ms_wb_byte_master.md
Name: ms_wb_byte_master

Overview:
Wishbone initiator controlled by a byte stream (UART RX/TX byte side or a host FIFO). It turns command packets into single Wishbone classic read/write cycles on the user-area slave bus (timer, UART and PSRAM controller windows) and returns status and read data as response bytes. It drives the wbs_* bus that the peripheral slaves decode, so the peripherals can be exercised without the management core.

Parameters:
BUS_TIMEOUT, 255, cycles with cyc/stb high and no ack before the cycle is abandoned (>=1)
RX_GAP_TIMEOUT, 65535, idle cycles allowed between command bytes before the partial packet is dropped (>=1)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous reset, active-low
rx_data_i  in  8  command byte
rx_valid_i  in  1  rx_data_i valid
rx_ready_o  out  1  block accepts byte; transfer when rx_valid_i & rx_ready_o
tx_data_o  out  8  response byte
tx_valid_o  out  1  tx_data_o valid
tx_ready_i  in  1  sink accepts byte; transfer when tx_valid_o & tx_ready_i
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  acknowledge
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: all outputs 0 except rx_ready_o = 1 (IDLE). Reset during a bus cycle drops cyc/stb immediately. No response byte is sent for the aborted packet.
- Packet format:
  - Opcode byte: 0x57 = write, 0x52 = read.
  - 4 address bytes, MSB first.
  - Write only: 4 data bytes, MSB first.
- States: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE: rx_ready_o = 1. On an accepted byte:
  - 0x57 or 0x52: latch the direction, go to ADDR.
  - Any other value: queue the single response 0xEE, go to RESP.
- ADDR: accept 4 bytes into the address shift register. After the 4th byte, go to WDATA for a write, or BUS for a read.
- WDATA: accept 4 bytes into wbm_dat_o. After the 4th byte, go to BUS.
- A 2-bit byte counter is cleared on every state entry.
- rx_ready_o = 1 only in IDLE, ADDR and WDATA.
- Gap timer:
  - Runs in ADDR and WDATA. It is cleared by every accepted byte.
  - When it reaches RX_GAP_TIMEOUT, the packet is discarded silently and the block returns to IDLE.
- BUS timing:
  - cyc, stb and we rise on the clock edge that enters BUS, i.e. the cycle after the last command byte is accepted. sel = 4'hF.
  - adr and dat are held stable for the whole cycle.
  - The first edge with wbm_ack_i = 1 ends the cycle: cyc/stb/we/sel are 0 from the next cycle on. Read data is captured on that edge.
  - A zero-wait-state ack (high in the first BUS cycle) is legal and is handled the same way.
- BUS timeout:
  - The counter increments each BUS cycle without ack. When it reaches BUS_TIMEOUT, the cycle is dropped.
  - If ack and the timeout occur on the same edge, ack wins.
- BUS responses (go to RESP):
  - Write acked: 0x4B.
  - Read acked: 0x4B, then 4 data bytes MSB first.
  - Timeout: the single byte 0x54; no data bytes for reads.
- RESP:
  - tx_valid_o is high; tx_data_o is stable until accepted.
  - The next byte is presented in the cycle after each transfer, with no bubble if tx_ready_i stays high.
  - After the last byte transfers, go to IDLE. RX bytes are not accepted during RESP or BUS.
- wbm_adr_o and wbm_dat_o keep their last values after a cycle; only cyc/stb/we/sel return to 0.
- Exactly one Wishbone cycle is issued per valid packet. There are no retries and no bursts.

Test Plan:
1. Write 57 30 00 00 04 DE AD BE EF with ack after 2 wait cycles -> one cycle with adr=0x30000004, dat=0xDEADBEEF, we=1, sel=F; tx emits 4B; busy_o low afterwards.
2. Read 52 30 02 00 08 with ack in the first BUS cycle and wbm_dat_i=0x12345678 -> we=0, cyc high exactly 1 cycle; tx emits 4B 12 34 56 78 in order.
3. Opcode 0x41 -> no Wishbone activity; tx emits EE; a following valid read completes normally.
4. Read with ack never asserted, BUS_TIMEOUT=8 -> stb high exactly 8 cycles, then low; tx emits 54 only. Repeat with ack on the 8th cycle -> 4B plus data.
5. Read response with tx_ready_i toggling 1/0 randomly -> every byte held stable while stalled; all 5 bytes delivered once, in order; rx_ready_o stays 0 until done.
6. Send 57 30 00, then idle RX_GAP_TIMEOUT cycles (set to 16) -> return to IDLE with no bus activity or tx. Separately, assert rst_n_i low mid-BUS -> cyc/stb drop asynchronously, and after release the block accepts a new packet.
